// File: rtl/bcd_time_pkg.sv
// rtl/bcd_time_pkg.sv - field widths, moduli and BCD helper for the timekeeper
package bcd_time_pkg;

    localparam int HT_W = 2;
    localparam int HU_W = 4;
    localparam int MT_W = 3;
    localparam int MU_W = 4;
    localparam int ST_W = 3;
    localparam int SU_W = 4;

    localparam int SEC_MOD  = 60;
    localparam int MIN_MOD  = 60;
    localparam int HOUR_MOD = 24;

    // A nibble is a legal decimal digit when it lies in 0..9
    function automatic logic bcd_valid(input logic [3:0] d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// rtl/bcd_digit_counter.sv - single BCD digit counter with load and wrap strobe
module bcd_digit_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] q,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 1);

    assign wrap = en && (q == Q_MAX);

    // Digit register: load beats count, count wraps to zero at the modulus
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= ld_val;
        end else if (en) begin
            q <= wrap ? '0 : q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/bcd_timekeeper.sv
// rtl/bcd_timekeeper.sv - HH:MM:SS BCD timekeeper with prescaler, load, adjust and 12h display
module bcd_timekeeper
    import bcd_time_pkg::*;
#(
    parameter int TICKS_PER_SEC = 250000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic            mode_12h,
    input  logic            load,
    input  logic [HT_W-1:0] ld_hour_tens,
    input  logic [HU_W-1:0] ld_hour_units,
    input  logic [MT_W-1:0] ld_min_tens,
    input  logic [MU_W-1:0] ld_min_units,
    input  logic [ST_W-1:0] ld_sec_tens,
    input  logic [SU_W-1:0] ld_sec_units,
    input  logic            inc_min,
    input  logic            inc_hour,
    output logic [HT_W-1:0] hour_tens,
    output logic [HU_W-1:0] hour_units,
    output logic [MT_W-1:0] min_tens,
    output logic [MU_W-1:0] min_units,
    output logic [ST_W-1:0] sec_tens,
    output logic [SU_W-1:0] sec_units,
    output logic            pm,
    output logic            sec_tick,
    output logic            day_tick,
    output logic            load_err
);

    localparam int PRESC_W = $clog2(TICKS_PER_SEC > 1 ? TICKS_PER_SEC : 2);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICKS_PER_SEC - 1);
    localparam logic [HT_W-1:0]    HT_LAST   = HT_W'((HOUR_MOD - 1) / 10);
    localparam logic [HU_W-1:0]    HU_LAST   = HU_W'((HOUR_MOD - 1) % 10);

    logic [PRESC_W-1:0] presc;
    logic [HT_W-1:0]    ht_q;
    logic [HU_W-1:0]    hu_q;
    logic               ld_ok, ld_accept, ld_reject;
    logic               adj, tick, do_inc_min, do_inc_hour;
    logic               su_wrap, st_wrap, mu_wrap, mt_wrap;
    logic               hour_carry, hour_en, hour_last;
    logic [4:0]         hour_bin, hour_disp;

    assign ld_ok = bcd_valid(4'(ld_hour_units)) && bcd_valid(4'(ld_min_units))
                && bcd_valid(4'(ld_sec_units))
                && (ld_sec_tens <= 3'd5) && (ld_min_tens <= 3'd5)
                && ((ld_hour_tens < 2'd2) || (ld_hour_tens == 2'd2 && ld_hour_units <= 4'd3));

    assign ld_accept   = load && ld_ok;
    assign ld_reject   = load && !ld_ok;
    assign adj         = inc_min || inc_hour;
    assign do_inc_min  = inc_min && !load;
    assign do_inc_hour = inc_hour && !load;
    // Adjust cycles freeze the prescaler, so a tick and an adjust never coincide
    assign tick        = run && !load && !adj && (presc == PRESC_MAX);

    // Prescaler: counts while running, holds on load/adjust, clears on accepted load
    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
        end else if (ld_accept) begin
            presc <= '0;
        end else if (run && !load && !adj) begin
            presc <= tick ? '0 : presc + PRESC_W'(1);
        end
    end

    bcd_digit_counter #(.WIDTH(SU_W), .MODULUS(10)) u_sec_units (
        .clk(clk), .reset(reset), .en(tick), .load(ld_accept),
        .ld_val(ld_sec_units), .q(sec_units), .wrap(su_wrap)
    );

    bcd_digit_counter #(.WIDTH(ST_W), .MODULUS(SEC_MOD / 10)) u_sec_tens (
        .clk(clk), .reset(reset), .en(su_wrap), .load(ld_accept),
        .ld_val(ld_sec_tens), .q(sec_tens), .wrap(st_wrap)
    );

    bcd_digit_counter #(.WIDTH(MU_W), .MODULUS(10)) u_min_units (
        .clk(clk), .reset(reset), .en(st_wrap || do_inc_min), .load(ld_accept),
        .ld_val(ld_min_units), .q(min_units), .wrap(mu_wrap)
    );

    bcd_digit_counter #(.WIDTH(MT_W), .MODULUS(MIN_MOD / 10)) u_min_tens (
        .clk(clk), .reset(reset), .en(mu_wrap), .load(ld_accept),
        .ld_val(ld_min_tens), .q(min_tens), .wrap(mt_wrap)
    );

    // Minute wrap from an adjust must not reach the hours, hence the tick qualifier
    assign hour_carry = mt_wrap && tick;
    assign hour_en    = hour_carry || do_inc_hour;
    assign hour_last  = (ht_q == HT_LAST) && (hu_q == HU_LAST);

    // Hour pair: 23 wraps to 00, otherwise ordinary two-digit BCD increment
    always_ff @(posedge clk) begin
        if (reset) begin
            ht_q <= '0;
            hu_q <= '0;
        end else if (ld_accept) begin
            ht_q <= ld_hour_tens;
            hu_q <= ld_hour_units;
        end else if (hour_en) begin
            if (hour_last) begin
                ht_q <= '0;
                hu_q <= '0;
            end else if (hu_q == 4'd9) begin
                ht_q <= ht_q + HT_W'(1);
                hu_q <= '0;
            end else begin
                hu_q <= hu_q + HU_W'(1);
            end
        end
    end

    // Strobes appear alongside the state they describe
    always_ff @(posedge clk) begin
        if (reset) begin
            sec_tick <= 1'b0;
            day_tick <= 1'b0;
            load_err <= 1'b0;
        end else begin
            sec_tick <= tick;
            day_tick <= hour_carry && hour_last;
            load_err <= ld_reject;
        end
    end

    assign hour_bin = 5'(ht_q) * 5'd10 + 5'(hu_q);
    assign pm       = hour_bin >= 5'd12;

    // Display hour: pass-through in 24h mode, 12..11 re-split to BCD in 12h mode
    always_comb begin
        hour_disp  = hour_bin;
        hour_tens  = ht_q;
        hour_units = hu_q;
        if (hour_bin == 5'd0) begin
            hour_disp = 5'd12;
        end else if (hour_bin > 5'd12) begin
            hour_disp = hour_bin - 5'd12;
        end
        if (mode_12h) begin
            if (hour_disp >= 5'd10) begin
                hour_tens  = 2'd1;
                hour_units = 4'(hour_disp - 5'd10);
            end else begin
                hour_tens  = 2'd0;
                hour_units = 4'(hour_disp);
            end
        end
    end

endmodule

// File: tb/tb_bcd_timekeeper.sv
// tb/tb_bcd_timekeeper.sv - directed self-checking bench for bcd_timekeeper
module tb_bcd_timekeeper;

    logic       clk = 1'b0;
    logic       reset, run, mode_12h, load, inc_min, inc_hour;
    logic [1:0] ld_hour_tens;
    logic [3:0] ld_hour_units, ld_min_units, ld_sec_units;
    logic [2:0] ld_min_tens, ld_sec_tens;
    logic [1:0] hour_tens;
    logic [3:0] hour_units, min_units, sec_units;
    logic [2:0] min_tens, sec_tens;
    logic       pm, sec_tick, day_tick, load_err;

    int vectors    = 0;
    int miscompares = 0;
    int ticks_seen;

    bcd_timekeeper #(.TICKS_PER_SEC(4)) dut (
        .clk(clk), .reset(reset), .run(run), .mode_12h(mode_12h), .load(load),
        .ld_hour_tens(ld_hour_tens), .ld_hour_units(ld_hour_units),
        .ld_min_tens(ld_min_tens), .ld_min_units(ld_min_units),
        .ld_sec_tens(ld_sec_tens), .ld_sec_units(ld_sec_units),
        .inc_min(inc_min), .inc_hour(inc_hour),
        .hour_tens(hour_tens), .hour_units(hour_units),
        .min_tens(min_tens), .min_units(min_units),
        .sec_tens(sec_tens), .sec_units(sec_units),
        .pm(pm), .sec_tick(sec_tick), .day_tick(day_tick), .load_err(load_err)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] now();
        return {2'b00, hour_tens, hour_units, 1'b0, min_tens, min_units,
                1'b0, sec_tens, sec_units};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [23:0] t);
        ld_hour_tens  = t[21:20];
        ld_hour_units = t[19:16];
        ld_min_tens   = t[14:12];
        ld_min_units  = t[11:8];
        ld_sec_tens   = t[6:4];
        ld_sec_units  = t[3:0];
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; mode_12h = 1'b0; load = 1'b0;
        inc_min = 1'b0; inc_hour = 1'b0;
        ld_hour_tens = '0; ld_hour_units = '0; ld_min_tens = '0;
        ld_min_units = '0; ld_sec_tens = '0; ld_sec_units = '0;
        step(); step();
        chk("reset_time", now(), 24'h000000);
        chk("reset_sec_tick", sec_tick, 1'b0);
        chk("reset_day_tick", day_tick, 1'b0);
        chk("reset_load_err", load_err, 1'b0);
        chk("reset_pm", pm, 1'b0);
        mode_12h = 1'b1; #1;
        chk("reset_12h", now(), 24'h120000);
        mode_12h = 1'b0;

        run = 1'b1; reset = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            step();
            chk("count_tick", sec_tick, (i % 4) == 0);
            if (i == 36) chk("count_sec9", now(), 24'h000009);
        end
        chk("count_40", now(), 24'h000010);
        chk("count_pm", pm, 1'b0);

        step(); step();
        run = 1'b0;
        ticks_seen = 0;
        repeat (100) begin
            step();
            if (sec_tick) ticks_seen++;
        end
        chk("freeze_ticks", 24'(ticks_seen), 24'd0);
        chk("freeze_time", now(), 24'h000010);
        run = 1'b1;
        step();
        chk("resume_no_tick", sec_tick, 1'b0);
        step();
        chk("resume_tick", sec_tick, 1'b1);
        chk("resume_time", now(), 24'h000011);
        run = 1'b0;

        do_load(24'h240000);
        chk("rej_h24_err", load_err, 1'b1);
        chk("rej_h24_time", now(), 24'h000011);
        step();
        chk("rej_err_clears", load_err, 1'b0);
        do_load(24'h12345A);
        chk("rej_su10_err", load_err, 1'b1);
        chk("rej_su10_time", now(), 24'h000011);
        step();
        do_load(24'h126000);
        chk("rej_mt6_err", load_err, 1'b1);
        chk("rej_mt6_time", now(), 24'h000011);
        step();
        do_load(24'h123456);
        chk("acc_err", load_err, 1'b0);
        chk("acc_time", now(), 24'h123456);
        chk("acc_no_tick", sec_tick, 1'b0);
        chk("acc_pm", pm, 1'b1);
        mode_12h = 1'b1; #1;
        chk("h12_noon", now(), 24'h123456);

        do_load(24'h130000);
        chk("h12_13", now(), 24'h010000);
        chk("h12_13_pm", pm, 1'b1);
        do_load(24'h231500);
        chk("h12_23", now(), 24'h111500);
        chk("h12_23_pm", pm, 1'b1);
        do_load(24'h095900);
        chk("h12_09", now(), 24'h095900);
        chk("h12_09_pm", pm, 1'b0);
        mode_12h = 1'b0;

        do_load(24'h055930);
        inc_min = 1'b1; step(); inc_min = 1'b0;
        chk("inc_min_wrap", now(), 24'h050030);
        chk("inc_min_no_tick", sec_tick, 1'b0);
        do_load(24'h234510);
        inc_hour = 1'b1; step(); inc_hour = 1'b0;
        chk("inc_hour_wrap", now(), 24'h004510);
        chk("inc_hour_no_day", day_tick, 1'b0);
        do_load(24'h235900);
        inc_min = 1'b1; inc_hour = 1'b1; step(); inc_min = 1'b0; inc_hour = 1'b0;
        chk("inc_both", now(), 24'h000000);
        chk("inc_both_no_day", day_tick, 1'b0);
        chk("inc_both_no_tick", sec_tick, 1'b0);

        do_load(24'h235958);
        run = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk("roll_sec_tick", sec_tick, (i % 4) == 0);
            chk("roll_day_tick", day_tick, i == 8);
            if (i == 4) chk("roll_235959", now(), 24'h235959);
            if (i == 8) begin
                chk("roll_midnight", now(), 24'h000000);
                chk("roll_pm", pm, 1'b0);
            end
        end
        run = 1'b0;

        do_load(24'h130203);
        run = 1'b1;
        step(); step(); step();
        inc_min = 1'b1; step(); inc_min = 1'b0;
        chk("defer_adj_time", now(), 24'h130303);
        chk("defer_adj_no_tick", sec_tick, 1'b0);
        step();
        chk("defer_tick", sec_tick, 1'b1);
        chk("defer_time", now(), 24'h130304);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("defer_next_tick", sec_tick, i == 4);
        end
        chk("defer_once", now(), 24'h130305);

        mode_12h = 1'b1; #1;
        chk("toggle_12h", now(), 24'h010305);
        chk("toggle_pm", pm, 1'b1);
        step(); step();
        mode_12h = 1'b0; #1;
        chk("toggle_24h", now(), 24'h130305);
        step(); step();
        chk("toggle_tick", sec_tick, 1'b1);
        chk("toggle_time", now(), 24'h130306);

        step(); step();
        reset = 1'b1; step();
        chk("midreset_time", now(), 24'h000000);
        chk("midreset_tick", sec_tick, 1'b0);
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("midreset_first_tick", sec_tick, i == 4);
        end
        chk("midreset_time1", now(), 24'h000001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bcd_timekeeper.md
Name: bcd_timekeeper

Overview:
- Parametrised successor of the HH:MM:SS clock core.
- Adds an internal prescaler, run/pause, a 12/24-hour display mode with PM flag, a validated full-time load, and per-field increment adjust that does not carry.
- Emits second and day-rollover strobes for the alarm/display blocks.
- Time is held internally as 24-hour BCD; only the hour outputs are mode-converted.

Parameters:
- TICKS_PER_SEC, 250000, clk cycles per second; must be >=1. The value 1 gives a tick every cycle for simulation.
- PRESC_W, $clog2(TICKS_PER_SEC>1 ? TICKS_PER_SEC : 2), prescaler width (derived, not overridden).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- run  in  1  1 = time advances; 0 = prescaler and time hold
- mode_12h  in  1  1 = hour outputs in 12-hour format
- load  in  1  single-cycle request to load ld_* (24-hour BCD)
- ld_hour_tens  in  2  BCD load value
- ld_hour_units  in  4  BCD load value
- ld_min_tens  in  3  BCD load value
- ld_min_units  in  4  BCD load value
- ld_sec_tens  in  3  BCD load value
- ld_sec_units  in  4  BCD load value
- inc_min  in  1  pulse: minutes +1, wraps 59->00, no carry into hours
- inc_hour  in  1  pulse: hours +1, wraps 23->00
- hour_tens  out  2  displayed hour tens
- hour_units  out  4  displayed hour units
- min_tens  out  3
- min_units  out  4
- sec_tens  out  3
- sec_units  out  4
- pm  out  1  1 when internal hour >= 12 (valid in both modes)
- sec_tick  out  1  one-cycle strobe, high in the first cycle new seconds are visible
- day_tick  out  1  one-cycle strobe, high in the first cycle 00:00:00 is visible after a 23:59:59 tick
- load_err  out  1  one-cycle strobe, high the cycle after a rejected load

Behaviour:
- Reset: internal time 00:00:00, prescaler 0, sec_tick/day_tick/load_err = 0. Display in 24h mode is 00:00:00, pm = 0. Display in 12h mode shows hour 12, pm = 0.
- Priority within a cycle: reset > load > inc_hour/inc_min > second tick.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1 while run=1.
  - A terminal count generates an internal tick and the prescaler wraps to 0.
  - Prescaler holds when run=0.
  - Prescaler holds during any cycle with inc_min or inc_hour, so the tick is deferred by one cycle, never lost.
  - Load clears the prescaler to 0.
- Tick:
  - Seconds +1; 59 -> 00 with carry to minutes.
  - Minutes 59 -> 00 with carry to hours.
  - Hours 23 -> 00 with day_tick.
  - Result registered; sec_tick asserted in the next cycle alongside the new value.
- Load:
  - Accepted only if every digit is a valid BCD digit, sec_tens <= 5, min_tens <= 5, and (hour_tens < 2, or hour_tens = 2 and hour_units <= 3).
  - Accepted: all six digits update at the edge, prescaler = 0, no sec_tick.
  - Rejected: state unchanged, load_err = 1 for one cycle.
  - Load with run=0 is legal.
- Adjust:
  - inc_min and inc_hour may be asserted together; both apply.
  - Adjust is honoured with run=0.
  - Adjust never produces sec_tick or day_tick.
- 12h conversion (combinational from registered state):
  - Hour 0 -> 12.
  - Hours 1..12 -> unchanged.
  - Hours 13..23 -> h-12.
  - Tens/units re-split to BCD.
  - pm is independent of mode.
- Changing mode_12h mid-operation affects only the outputs, immediately; no state change.
- Reset asserted mid-second discards the partial prescaler count.

Decomposition:
- Package bcd_time_pkg:
  - Field widths (HT_W=2, HU_W=4, MT_W=3, MU_W=4, ST_W=3, SU_W=4).
  - Moduli constants SEC_MOD=60, MIN_MOD=60, HOUR_MOD=24.
  - Function bcd_valid.
- Sub-module bcd_digit_counter, instantiated per digit:
  - Parameters WIDTH and MODULUS.
  - Ports clk, reset, en, load, ld_val, q, wrap; wrap = en && q==MODULUS-1.
- Hour pair is a special case: 23 -> 00 wrap logic is in the top level.

Test Plan:
- Reset, TICKS_PER_SEC=4, run=1 for 40 cycles -> sec_units reaches 9 at cycle ~36; each sec_tick spaced 4 cycles; pm=0.
- Load 23:59:58, TICKS_PER_SEC=1, run=1 -> 23:59:59, then 00:00:00 with day_tick=1 for exactly that cycle, sec_tick each cycle.
- Load hour 2/4 (24) -> load_err pulse, time unchanged. Load sec_units=10 -> load_err. Load 12:34:56 -> accepted, no load_err.
- At 05:59:30, inc_min -> 05:00:30 (no carry). At 23:xx, inc_hour -> 00:xx, no day_tick. inc_min coincident with prescaler terminal -> sec_tick one cycle later, seconds advance exactly once.
- mode_12h=1: internal 00 -> 12/pm=0; 12 -> 12/pm=1; 13 -> 01/pm=1; 23 -> 11/pm=1. Toggle mode mid-run -> outputs change same cycle, seconds unaffected.
- run=0 for 100 cycles -> digits and prescaler frozen. Reset asserted mid-second -> 00:00:00; first sec_tick exactly TICKS_PER_SEC cycles after reset release.
